data_pack_builder: RTL and testbench
====================================

# data_pack_builder

Transmit-side packet builder for the endpoint data path: accepts a 72-bit data word, computes its CRC16 with the existing `CRC16_D72` generator, and frames it as the 96-bit packet that the receive-side unpacker consumes. The packet layout is header `[95:88]`, data `[87:16]`, CRC `[15:0]`. The packet is also streamed out MSB-first as 12 bytes on an 8-bit valid/ready link, so the block sits between the data producer and the byte-wide channel.

## Interface
- `HEADER`, default 8'h3C: header byte placed in `packet[95:88]`.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_data`  in  72  payload word to frame.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a word.
- `packet`  out  96  registered, framed packet `{HEADER, data, crc}`; holds the last captured packet.
- `tx_byte`  out  8  current byte of the serialized packet.
- `tx_valid`  out  1  `tx_byte` is valid.
- `tx_ready`  in  1  downstream accepts `tx_byte` this cycle.
- `tx_sop`  out  1  qualifies byte 0 (the header).
- `tx_eop`  out  1  qualifies byte 11 (CRC low byte).
- `busy`  out  1  a packet is being serialized.
- `pkt_count`  out  16  number of packets fully sent (eop accepted); wraps.

## Operation
- Instantiates `CRC16_D72` with `Data` = `in_data`, `crc` (initial value) = 16'h0000. This is the same seed the receiver checks against.
- State machine: IDLE, SEND.
- **IDLE**
  - `in_ready` = 1, `tx_valid` = 0, `busy` = 0.
  - On `in_valid & in_ready`: `packet` <= {HEADER, in_data, crc_out}, byte index `idx` <= 0, next state SEND.
  - `in_data` without `in_valid` is ignored.
- **SEND**
  - `in_ready` = 0, `busy` = 1, `tx_valid` = 1.
  - `tx_byte` = `packet[95-8*idx -: 8]` (byte 0 = HEADER, bytes 1–9 = data MSB first, bytes 10–11 = CRC high then low).
  - `tx_sop` = (idx == 0); `tx_eop` = (idx == 11).
  - On `tx_ready` with idx < 11: idx <= idx + 1.
  - On `tx_ready` with idx == 11: `pkt_count` <= `pkt_count` + 1 (wraps 16'hFFFF -> 0), next state IDLE.
  - With `tx_ready` low: `tx_byte`, `tx_sop`, `tx_eop` and idx hold; there is no timeout.
- `tx_valid`, once raised, stays high until the eop byte is accepted. Dropping it mid-packet is a bug.
- `in_valid` during SEND is not accepted; the producer must hold its word until `in_ready`.
- `packet` changes only on a capture, never during SEND.
- **Reset** (at any time, including mid-packet):
  - state IDLE, idx 0, `packet` 96'h0, `pkt_count` 0.
  - `tx_valid`/`tx_sop`/`tx_eop`/`busy` 0.
  - `in_ready` forced 0 while `reset` is high.
  - A partial packet is abandoned and not counted.

## Timing
- Capture edge T (`in_valid & in_ready` sampled high): `packet` valid and `tx_valid`/`tx_sop` high with the HEADER byte from T+1.
- With `tx_ready` held high, bytes 0–11 occupy cycles T+1..T+12. The eop handshake is at edge T+12, and `in_ready` is high again in cycle T+13.
- Minimum packet period is 13 cycles (one IDLE bubble between packets). There is no combinational path from `tx_ready` to `in_ready`.
- Each `tx_ready` low cycle adds one cycle of latency.
- CRC is combinational from `in_data` into the capture register. There is no extra pipeline stage.
- All outputs are registered or decoded from registered state/idx only.

## Test plan
- **Reset then idle.** Assert `reset` mid-cycle, release it -> all outputs 0 during reset. After release, `in_ready`=1 and `tx_valid`=0.
- **All-zero payload.** `in_data`=72'h0, `tx_ready`=1 -> `packet`=96'h3C00_0000_0000_0000_0000_0000. Bytes 3C then eleven 00, sop on byte 0, eop on byte 11, `pkt_count`=1, `in_ready` back at T+13.
- **Nonzero payload.** `in_data`=72'h01_2345_6789_ABCD_EF01 -> `packet[87:16]` equals the input, `packet[15:0]` matches the `CRC16_D72` model with seed 0, bytes 1–9 = 01 23 45 67 89 AB CD EF 01. Feeding `packet` to the receiver yields data unchanged and no mismatch.
- **Backpressure.** Toggle `tx_ready` pseudo-randomly -> byte, sop and eop stable while stalled, no byte skipped or duplicated, exactly 12 handshakes per packet. `in_valid` during SEND is not accepted.
- **Reset mid-packet.** Assert `reset` after byte 5 is accepted -> `tx_valid` drops immediately and `pkt_count` is unchanged (0). The next packet starts from header byte 3C.
- **Counter wrap.** Preload to 16'hFFFF by sending 65535 packets (or force in sim), then send one more -> `pkt_count`=16'h0000.

Source files
------------

// File: rtl/data_pack_builder.sv
`default_nettype none
// ============================================================================
// data_pack_builder: frames a 72-bit word as {HEADER, data, CRC16} and streams
// it MSB-first as 12 bytes over a valid/ready byte link.   Rev 1.0
// ============================================================================

module CRC16_D72 (
    input  logic [71:0] Data,
    input  logic [15:0] crc,
    output logic [15:0] newcrc
);
    logic [15:0] c;
    logic        fb;

    // Bit-serial equivalent of polynomial 0x8005, data consumed from bit 71 down.
    always_comb begin
        c  = crc;
        fb = 1'b0;
        for (int i = 71; i >= 0; i--) begin
            fb = c[15] ^ Data[i];
            c  = {c[14:0], 1'b0};
            if (fb) begin
                c = c ^ 16'h8005;
            end
        end
        newcrc = c;
    end
endmodule

module data_pack_builder #(
    parameter logic [7:0] HEADER = 8'h3C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [71:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [95:0] packet,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_sop,
    output logic        tx_eop,
    output logic        busy,
    output logic [15:0] pkt_count
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  idx;
    logic [3:0]  idx_next;
    logic        capture;
    logic        count_inc;
    logic [15:0] crc_out;
    logic [95:0] shifted;

    CRC16_D72 u_crc (
        .Data   (in_data),
        .crc    (16'h0000),
        .newcrc (crc_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        capture    = 1'b0;
        count_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    capture    = 1'b1;
                    idx_next   = 4'd0;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (idx == 4'd11) begin
                        count_inc  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        idx_next = idx + 4'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Every output is a decode of registered state, idx and packet.
    always_comb begin
        shifted  = packet << {idx, 3'b000};
        tx_byte  = shifted[95:88];
        in_ready = (state == IDLE) && !reset;
        tx_valid = (state == SEND);
        busy     = (state == SEND);
        tx_sop   = (state == SEND) && (idx == 4'd0);
        tx_eop   = (state == SEND) && (idx == 4'd11);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx       <= 4'd0;
            packet    <= 96'h0;
            pkt_count <= 16'h0000;
        end else begin
            idx <= idx_next;
            if (capture) begin
                packet <= {HEADER, in_data, crc_out};
            end
            if (count_inc) begin
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_data_pack_builder.sv
`default_nettype none
// Directed bench for data_pack_builder: framing, CRC, serialization,
// backpressure, reset mid-packet and counter wrap.

module tb_data_pack_builder;
    logic        clk = 1'b0;
    logic        reset;
    logic [71:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [95:0] packet;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_sop;
    logic        tx_eop;
    logic        busy;
    logic [15:0] pkt_count;

    int          tests  = 0;
    int          failed = 0;
    logic [15:0] exp_count = 16'h0000;

    data_pack_builder #(.HEADER(8'h3C)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .packet    (packet),
        .tx_byte   (tx_byte),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_sop    (tx_sop),
        .tx_eop    (tx_eop),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    // Byte-at-a-time CRC-16 (poly 0x8005, init 0, no reflection).
    function automatic logic [15:0] crc_model(input logic [71:0] d);
        logic [15:0] c;
        c = 16'h0000;
        for (int b = 8; b >= 0; b--) begin
            c = c ^ {d[8*b+7 -: 8], 8'h00};
            for (int j = 0; j < 8; j++) begin
                c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
            end
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offers d, then accepts nbytes bytes (optionally with stalls), checking
    // every cycle. Returns at the negedge after the last accepted byte.
    task automatic run_packet(input logic [71:0] d, input bit stall, input int nbytes,
                              output int cycles);
        logic [95:0] exp_pkt;
        int k;
        int guard;
        exp_pkt = {8'h3C, d, crc_model(d)};
        @(negedge clk);
        check("in_ready_before", {95'h0, in_ready}, 96'h1);
        in_data  = d;
        in_valid = 1'b1;
        tx_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~d;
        check("packet_captured", packet, exp_pkt);
        k      = 0;
        guard  = 0;
        cycles = 1;
        while (k < nbytes && guard < 200) begin
            tx_ready = (stall && ((guard % 3) == 0 || $urandom_range(0, 1) == 0)) ? 1'b0 : 1'b1;
            in_valid = ~tx_ready;
            check("tx_valid",  {95'h0, tx_valid}, 96'h1);
            check("busy",      {95'h0, busy},     96'h1);
            check("in_ready_send", {95'h0, in_ready}, 96'h0);
            check("tx_byte",   {88'h0, tx_byte},  {88'h0, exp_pkt[95-8*k -: 8]});
            check("tx_sop",    {95'h0, tx_sop},   {95'h0, (k == 0)});
            check("tx_eop",    {95'h0, tx_eop},   {95'h0, (k == 11)});
            check("packet_hold", packet, exp_pkt);
            @(negedge clk);
            if (tx_ready) k++;
            guard++;
            cycles++;
        end
        tx_ready = 1'b0;
        in_valid = 1'b0;
        check("handshakes", k, nbytes);
        if (nbytes == 12) begin
            exp_count = exp_count + 16'd1;
            check("idle_tx_valid", {95'h0, tx_valid}, 96'h0);
            check("idle_in_ready", {95'h0, in_ready}, 96'h1);
            check("pkt_count", {80'h0, pkt_count}, {80'h0, exp_count});
        end
    endtask

    initial begin
        int cyc;
        reset    = 1'b1;
        in_data  = 72'h0;
        in_valid = 1'b0;
        tx_ready = 1'b0;

        // Reset then idle
        #13;
        in_valid = 1'b1;
        #1;
        check("rst_in_ready",  {95'h0, in_ready},  96'h0);
        check("rst_tx_valid",  {95'h0, tx_valid},  96'h0);
        check("rst_busy",      {95'h0, busy},      96'h0);
        check("rst_sop_eop",   {94'h0, tx_sop, tx_eop}, 96'h0);
        check("rst_packet",    packet, 96'h0);
        check("rst_pkt_count", {80'h0, pkt_count}, 96'h0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("idle_in_ready0", {95'h0, in_ready}, 96'h1);
        check("idle_tx_valid0", {95'h0, tx_valid}, 96'h0);
        @(negedge clk);
        check("idle_ignores_data", packet, 96'h0);

        // All-zero payload, 13-cycle period
        run_packet(72'h0, 1'b0, 12, cyc);
        check("zero_packet", packet, 96'h3C00_0000_0000_0000_0000_0000);
        check("zero_period", cyc, 13);

        // Nonzero payload
        run_packet(72'h01_2345_6789_ABCD_EF01, 1'b0, 12, cyc);
        check("nz_data", {24'h0, packet[87:16]}, {24'h0, 72'h01_2345_6789_ABCD_EF01});
        check("nz_crc",  {80'h0, packet[15:0]}, {80'h0, crc_model(72'h01_2345_6789_ABCD_EF01)});

        // ASCII "123456789": standard check value 0xFEE8
        run_packet(72'h31_3233_3435_3637_3839, 1'b0, 12, cyc);
        check("ascii_crc", {80'h0, packet[15:0]}, 96'hFEE8);

        // Backpressure with in_valid offered during SEND
        run_packet(72'hA5_5AC3_3C0F_F096_69E1, 1'b1, 12, cyc);
        check("bp_packet", packet, {8'h3C, 72'hA5_5AC3_3C0F_F096_69E1,
                                    crc_model(72'hA5_5AC3_3C0F_F096_69E1)});

        // Reset after byte 5 accepted
        run_packet(72'hDE_ADBE_EF01_0203_0405, 1'b0, 6, cyc);
        reset = 1'b1;
        #1;
        check("mid_rst_tx_valid",  {95'h0, tx_valid}, 96'h0);
        check("mid_rst_in_ready",  {95'h0, in_ready}, 96'h0);
        check("mid_rst_packet",    packet, 96'h0);
        check("mid_rst_pkt_count", {80'h0, pkt_count}, 96'h0);
        @(negedge clk);
        reset = 1'b0;
        exp_count = 16'h0000;
        #1;
        check("post_rst_in_ready", {95'h0, in_ready}, 96'h1);
        run_packet(72'h11_2233_4455_6677_8899, 1'b0, 12, cyc);
        check("post_rst_header", {88'h0, packet[95:88]}, 96'h3C);

        // Counter wrap
        @(negedge clk);
        force dut.pkt_count = 16'hFFFF;
        @(negedge clk);
        release dut.pkt_count;
        @(negedge clk);
        check("preload", {80'h0, pkt_count}, 96'hFFFF);
        exp_count = 16'hFFFF;
        run_packet(72'h00_0000_0000_0000_0001, 1'b0, 12, cyc);
        check("wrap", {80'h0, pkt_count}, 96'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

`default_nettype wire
